// File: rtl/pc_update_ctrl_if.sv
// PC update control bus between the main control unit
// and the PC update sequencer.
interface pc_update_ctrl_if;
  logic        inc_req;
  logic        xfer_req;
  logic [1:0]  op_kind;
  logic        branch_taken;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic [3:0]  PCSource;
  logic        PCWrite;
  logic        EPCWrite;
  logic        exc_mem_read;
  logic [31:0] exc_addr;
  logic        busy;
  logic        done;

  modport master (
    output inc_req, xfer_req, op_kind, branch_taken,
    output exc_opcode, exc_ovf, exc_div0,
    input  PCSource, PCWrite, EPCWrite,
    input  exc_mem_read, exc_addr, busy, done
  );

  modport slave (
    input  inc_req, xfer_req, op_kind, branch_taken,
    input  exc_opcode, exc_ovf, exc_div0,
    output PCSource, PCWrite, EPCWrite,
    output exc_mem_read, exc_addr, busy, done
  );
endinterface

// File: rtl/pc_update_ctrl.sv
// Multicycle PC update sequencer: increment, transfers, exception entry.
// Optional PCU_CAUSE_REG_EN adds a registered exception cause output.
module pc_update_ctrl #(
  parameter int unsigned MEM_WAIT = 1,
  parameter logic [31:0] VEC_BASE = 32'd253
) (
  input  logic             clk,
  input  logic             reset,
  pc_update_ctrl_if.slave  bus
`ifdef PCU_CAUSE_REG_EN
  ,
  output logic [1:0]       cause
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    UPD,
    EXC_EPC,
    EXC_WAIT,
    EXC_LOAD
  } state_t;

  localparam bit       WAIT_EN   = (MEM_WAIT != 0);
  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  src_q, src_d;
  logic        pcw_q, pcw_d;
  logic        epcw_q, epcw_d;
  logic        mr_q, mr_d;
  logic [31:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        exc_any;
  logic [1:0]  exc_off;
  logic [3:0]  kind_src;
`ifdef PCU_CAUSE_REG_EN
  logic [1:0]  cause_q, cause_d;
`endif

  // Exception cause priority and op_kind to source mapping
  always_comb begin
    exc_any = bus.exc_opcode | bus.exc_ovf | bus.exc_div0;
    exc_off = 2'd2;
    if (bus.exc_opcode)
      exc_off = 2'd0;
    else if (bus.exc_ovf)
      exc_off = 2'd1;
    kind_src = 4'd0;
    unique case (bus.op_kind)
      2'd0: kind_src = 4'd1;
      2'd1: kind_src = 4'd2;
      2'd2: kind_src = 4'd0;
      2'd3: kind_src = 4'd3;
      default: kind_src = 4'd0;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = 4'd0;
    pcw_d   = 1'b0;
    epcw_d  = 1'b0;
    mr_d    = 1'b0;
    addr_d  = 32'd0;
    done_d  = 1'b0;
`ifdef PCU_CAUSE_REG_EN
    cause_d = cause_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (exc_any) begin
          state_d = EXC_EPC;
          epcw_d  = 1'b1;
          mr_d    = 1'b1;
          addr_d  = VEC_BASE + {30'd0, exc_off};
`ifdef PCU_CAUSE_REG_EN
          cause_d = exc_off + 2'd1;
`endif
        end else if (bus.xfer_req) begin
          state_d = UPD;
          src_d   = kind_src;
          pcw_d   = !((bus.op_kind == 2'd0) && !bus.branch_taken);
          done_d  = 1'b1;
`ifdef PCU_CAUSE_REG_EN
          if (bus.op_kind == 2'd3)
            cause_d = 2'd0;
`endif
        end else if (bus.inc_req) begin
          state_d = UPD;
          pcw_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      UPD: state_d = IDLE;
      EXC_EPC: begin
        addr_d = addr_q;
        if (WAIT_EN) begin
          state_d = EXC_WAIT;
          mr_d    = 1'b1;
          cnt_d   = WAIT_LAST;
        end else begin
          state_d = EXC_LOAD;
          src_d   = 4'd4;
          pcw_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      EXC_WAIT: begin
        addr_d = addr_q;
        if (cnt_q == 3'd0) begin
          state_d = EXC_LOAD;
          src_d   = 4'd4;
          pcw_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          mr_d  = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end
      end
      EXC_LOAD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      src_q   <= 4'd0;
      pcw_q   <= 1'b0;
      epcw_q  <= 1'b0;
      mr_q    <= 1'b0;
      addr_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PCU_CAUSE_REG_EN
      cause_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      pcw_q   <= pcw_d;
      epcw_q  <= epcw_d;
      mr_q    <= mr_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PCU_CAUSE_REG_EN
      cause_q <= cause_d;
`endif
    end
  end

  assign bus.PCSource     = src_q;
  assign bus.PCWrite      = pcw_q;
  assign bus.EPCWrite     = epcw_q;
  assign bus.exc_mem_read = mr_q;
  assign bus.exc_addr     = addr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
`ifdef PCU_CAUSE_REG_EN
  assign cause = cause_q;
`endif

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Bench for pc_update_ctrl: two instances (MEM_WAIT=1 and 0)
// checked cycle by cycle against a transaction-level model.
module tb_pc_update_ctrl;

  typedef struct packed {
    logic [3:0]  src;
    logic        pcw;
    logic        epcw;
    logic        mr;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic [1:0]  cz;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  rec_t q0[$];
  rec_t q1[$];
  logic [1:0] cause_m = 2'd0;
  logic [1:0] cz0, cz1;

  pc_update_ctrl_if a ();
  pc_update_ctrl_if b ();

  pc_update_ctrl #(.MEM_WAIT(1), .VEC_BASE(32'd253)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a)
`ifdef PCU_CAUSE_REG_EN
    ,
    .cause (cz0)
`endif
  );

  pc_update_ctrl #(.MEM_WAIT(0), .VEC_BASE(32'd253)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
`ifdef PCU_CAUSE_REG_EN
    ,
    .cause (cz1)
`endif
  );

`ifndef PCU_CAUSE_REG_EN
  assign cz0 = 2'd0;
  assign cz1 = 2'd0;
`endif

  always #5 clk = ~clk;

  function automatic rec_t samp_a();
    rec_t r;
    r.src = a.PCSource; r.pcw = a.PCWrite;
    r.epcw = a.EPCWrite; r.mr = a.exc_mem_read;
    r.addr = a.exc_addr; r.busy = a.busy;
    r.done = a.done; r.cz = cz0;
    return r;
  endfunction

  function automatic rec_t samp_b();
    rec_t r;
    r.src = b.PCSource; r.pcw = b.PCWrite;
    r.epcw = b.EPCWrite; r.mr = b.exc_mem_read;
    r.addr = b.exc_addr; r.busy = b.busy;
    r.done = b.done; r.cz = cz1;
    return r;
  endfunction

  function automatic void put(int id, rec_t r);
`ifndef PCU_CAUSE_REG_EN
    r.cz = 2'd0;
`endif
    if (id == 0) q0.push_back(r);
    else q1.push_back(r);
  endfunction

  // Expected per-cycle trace of one accepted request
  function automatic void model(
    int id, int mw, logic [2:0] ex, logic xf,
    logic [1:0] k, logic tk, logic inc,
    input logic [1:0] cin, output logic [1:0] cout);
    rec_t r;
    int off;
    logic [3:0] srcmap [4];
    srcmap = '{4'd1, 4'd2, 4'd0, 4'd3};
    cout = cin;
    if (ex != 3'b000) begin
      off = ex[0] ? 0 : (ex[1] ? 1 : 2);
      cout = 2'(off + 1);
      r = '0; r.epcw = 1; r.mr = 1; r.busy = 1;
      r.addr = 32'(253 + off); r.cz = cout;
      put(id, r);
      for (int i = 0; i < mw; i++) begin
        r = '0; r.mr = 1; r.busy = 1;
        r.addr = 32'(253 + off); r.cz = cout;
        put(id, r);
      end
      r = '0; r.src = 4'd4; r.pcw = 1; r.done = 1; r.busy = 1;
      r.addr = 32'(253 + off); r.cz = cout;
      put(id, r);
    end else if (xf) begin
      if (k == 2'd3) cout = 2'd0;
      r = '0; r.src = srcmap[k]; r.done = 1; r.busy = 1;
      r.pcw = !(k == 2'd0 && !tk); r.cz = cout;
      put(id, r);
    end else if (inc) begin
      r = '0; r.pcw = 1; r.done = 1; r.busy = 1; r.cz = cout;
      put(id, r);
    end
    r = '0; r.cz = cout;
    put(id, r);
  endfunction

  task automatic chk(string tag, rec_t o, rec_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk1(string tag, logic o, logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic clr_a();
    a.inc_req = 0; a.xfer_req = 0; a.op_kind = 0;
    a.branch_taken = 0; a.exc_opcode = 0;
    a.exc_ovf = 0; a.exc_div0 = 0;
  endtask

  task automatic clr_b();
    b.inc_req = 0; b.xfer_req = 0; b.op_kind = 0;
    b.branch_taken = 0; b.exc_opcode = 0;
    b.exc_ovf = 0; b.exc_div0 = 0;
  endtask

  task automatic drive(logic [2:0] ex, logic xf,
                       logic [1:0] k, logic tk, logic inc);
    a.exc_opcode = ex[0]; a.exc_ovf = ex[1]; a.exc_div0 = ex[2];
    a.xfer_req = xf; a.op_kind = k;
    a.branch_taken = tk; a.inc_req = inc;
    b.exc_opcode = ex[0]; b.exc_ovf = ex[1]; b.exc_div0 = ex[2];
    b.xfer_req = xf; b.op_kind = k;
    b.branch_taken = tk; b.inc_req = inc;
  endtask

  task automatic txn(string tag, logic [2:0] ex, logic xf,
                     logic [1:0] k, logic tk, logic inc);
    logic [1:0] c0, c1;
    rec_t e;
    model(0, 1, ex, xf, k, tk, inc, cause_m, c0);
    model(1, 0, ex, xf, k, tk, inc, cause_m, c1);
    cause_m = c0;
    drive(ex, xf, k, tk, inc);
    while (q0.size() != 0 || q1.size() != 0) begin
      @(negedge clk);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk({tag, "_w1"}, samp_a(), e);
        if (e.done) clr_a();
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk({tag, "_w0"}, samp_b(), e);
        if (e.done) clr_b();
      end
    end
    clr_a();
    clr_b();
  endtask

  initial begin
    rec_t z;
    logic [2:0] ex;
    clr_a();
    clr_b();
    z = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_w1", samp_a(), z);
    chk("reset_w0", samp_b(), z);
    reset = 1'b0;

    txn("inc", 3'b000, 0, 2'd0, 0, 1);
    txn("br_nt", 3'b000, 1, 2'd0, 0, 0);
    txn("br_t", 3'b000, 1, 2'd0, 1, 0);
    txn("jmp", 3'b000, 1, 2'd1, 0, 1);
    txn("jr", 3'b000, 1, 2'd2, 1, 0);
    txn("ovf_inc", 3'b010, 0, 2'd0, 0, 1);
    txn("opc_div0", 3'b101, 1, 2'd1, 0, 0);
    txn("div0", 3'b100, 0, 2'd0, 0, 0);
    txn("rte", 3'b000, 1, 2'd3, 0, 0);
    txn("idle", 3'b000, 0, 2'd0, 0, 0);

    drive(3'b010, 0, 2'd0, 0, 0);
    @(negedge clk);
    chk1("rst_epc", a.EPCWrite, 1'b1);
    @(negedge clk);
    chk1("rst_wait_mr", a.exc_mem_read, 1'b1);
    chk1("rst_wait_pcw", a.PCWrite, 1'b0);
    reset = 1'b1;
    clr_a();
    clr_b();
    cause_m = 2'd0;
    @(negedge clk);
    chk("rst_mid_w1", samp_a(), z);
    chk("rst_mid_w0", samp_b(), z);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_w1", samp_a(), z);
    txn("rte2", 3'b000, 1, 2'd3, 0, 0);

    for (int i = 0; i < 60; i++) begin
      ex = ($urandom_range(0, 3) == 0) ?
           3'($urandom_range(1, 7)) : 3'b000;
      txn("rand", ex, 1'($urandom), 2'($urandom),
          1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_update_ctrl.md
Name: pc_update_ctrl

Overview:
- Multicycle sequencer that drives the PC-source select, PCWrite and EPCWrite controls for the PC update path.
- Selectable PC sources: ALU result, ALUOut, shifted jump target, EPC, and sign-extended exception vector byte.
- Arbitrates between sequential increment, control-transfer requests (branch/j/jr/rte) and exceptions.
- For exceptions, runs the full entry sequence: save EPC, read the vector byte from memory, load the PC.
- Sits between the main control unit and the PC/EPC registers.

Parameters:
- MEM_WAIT, 1: extra wait cycles between issuing the vector-byte memory read and using its data; legal range 0..7.
- VEC_BASE, 253: memory byte address of the first exception vector, as a 32-bit value.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- inc_req  in  1  request PC <= PC+4, with the value presented on ALU_Result.
- xfer_req  in  1  request a control transfer of kind op_kind.
- op_kind  in  2  0=branch (ALUOut), 1=j/jal (Shift_28), 2=jr (ALU_Result), 3=rte (EPC_Out).
- branch_taken  in  1  branch condition result; sampled with xfer_req.
- exc_opcode  in  1  invalid opcode exception.
- exc_ovf  in  1  arithmetic overflow exception.
- exc_div0  in  1  divide-by-zero exception.
- PCSource  out  4  source select: 0=ALU_Result, 1=ALUOut, 2=Shift_28, 3=EPC_Out, 4=Sign_8_32.
- PCWrite  out  1  PC load enable.
- EPCWrite  out  1  EPC load enable.
- exc_mem_read  out  1  memory read request for the vector byte.
- exc_addr  out  32  vector byte address.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset: all outputs 0, PCSource=0, exc_addr=0, state IDLE.
  - Reset is synchronous, active-high, and takes priority over everything, including mid-sequence.
  - Reset aborts any sequence with no PCWrite/EPCWrite issued.
- All outputs are registered.
- Requests are level inputs, sampled only on the clock edge while in IDLE.
  - Requests are ignored while busy; nothing is queued.
  - The requester holds its request until it sees done, then deasserts on the next cycle.
- Acceptance priority: any exception > xfer_req > inc_req.
  - Exception cause priority: exc_opcode (vector VEC_BASE+0) > exc_ovf (+1) > exc_div0 (+2).
- States:
  - IDLE: outputs 0.
  - UPD: entered on the edge that accepts inc_req or xfer_req; lasts 1 cycle.
    - inc_req: PCSource=0.
    - xfer_req: PCSource per op_kind.
    - PCWrite=1, except for a branch with branch_taken=0 sampled at acceptance, where PCWrite=0.
    - done=1, busy=1; next state IDLE.
  - EXC_EPC: 1 cycle. EPCWrite=1, exc_mem_read=1, exc_addr=VEC_BASE+cause offset.
  - EXC_WAIT: MEM_WAIT cycles via an internal down-counter; exc_mem_read=1 and exc_addr held. Skipped when MEM_WAIT=0.
  - EXC_LOAD: 1 cycle. PCSource=4, PCWrite=1, done=1, exc_mem_read=0, exc_addr still held. Next state IDLE.
- Latency, with acceptance at edge t:
  - UPD: PCWrite in cycle t+1.
  - Exception: EPCWrite in cycle t+1, PCWrite in cycle t+2+MEM_WAIT.
- Invariants:
  - PCWrite and EPCWrite are never high in the same cycle.
  - done is never high for 2 consecutive cycles.
- exc_addr returns to 0 in IDLE and UPD.
- The PC update takes effect at the edge ending the PCWrite cycle; the source data is the datapath's responsibility.

Optional Feature:
- Macro: PCU_CAUSE_REG_EN.
- When defined:
  - Extra output port cause, 2 bits: 0=none, 1=opcode, 2=ovf, 3=div0.
  - Loaded on the EXC_EPC cycle and held until the next exception or reset.
  - Reset value 0.
  - Cleared to 0 in the UPD cycle of an rte transfer (op_kind=3).
- When undefined: no cause port and no register. All other behaviour is identical.

Test Plan:
- inc_req=1 at edge 1 → cycle 2: PCSource=0, PCWrite=1, done=1, busy=1; cycle 3: all 0.
- xfer_req with op_kind=0, branch_taken=0 → UPD cycle: PCSource=1, PCWrite=0, done=1. With branch_taken=1, the same cycle has PCWrite=1.
- exc_ovf=1 with inc_req=1, MEM_WAIT=1:
  - Cycle 2: EPCWrite=1, exc_mem_read=1, exc_addr=254.
  - Cycle 3: exc_mem_read=1.
  - Cycle 4: PCSource=4, PCWrite=1, done=1.
  - inc_req is never serviced in that window.
- exc_opcode=1 and exc_div0=1 together → exc_addr=253. Rerun with MEM_WAIT=0: PCWrite arrives in cycle 3.
- Reset asserted in EXC_WAIT → next cycle: all outputs 0, no PCWrite issued. A subsequent xfer_req with op_kind=3 gives PCSource=3, PCWrite=1.
- With PCU_CAUSE_REG_EN defined:
  - exc_div0 sequence → cause=3 from cycle 2 onward.
  - An rte transfer then clears cause to 0.
